// File: rtl/ni_tx.sv
// ni_tx: network-interface transmit side; packs PE headers and payload words into 64-bit mesh flits.
// Build option NI_TX_SEQ_EN adds an 8-bit per-node packet sequence number to every head flit.
module ni_tx #(
    parameter int SRC_X   = 1,
    parameter int SRC_Y   = 1,
    parameter int MAX_LEN = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_dest_x,
    input  logic [2:0]  req_dest_y,
    input  logic [3:0]  req_len,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [31:0] data,
    output logic [63:0] flit_out,
    input  logic        link_ready,
    output logic        busy,
    output logic        pkt_sent,
    output logic        err_len
);
    // state   | meaning
    // IDLE    | waiting for a header; the only state that accepts req_valid
    // HEAD    | head flit loaded, no payload word taken yet
    // PAYLOAD | at least one payload word taken; leaves when the tail is consumed
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HEAD    = 2'd1;
    localparam logic [1:0] PAYLOAD = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] flit_q, flit_d;
    logic [3:0]  rem_q, rem_d;
    logic        pkt_sent_q, pkt_sent_d;
    logic        err_len_q, err_len_d;
    logic [7:0]  seq_val;
    logic        len_ok, consume, tail_done, data_rdy, data_hs;

    assign len_ok    = (req_len != 4'd0) && (req_len <= 4'(MAX_LEN));
    assign consume   = flit_q[63] && link_ready;
    assign tail_done = consume && (flit_q[62:61] == 2'b10);
    // A new word may be taken while the current flit leaves at the same edge.
    assign data_rdy  = (state_q != IDLE) && (rem_q != 4'd0) && (!flit_q[63] || link_ready);
    assign data_hs   = data_valid && data_rdy;

`ifdef NI_TX_SEQ_EN
    logic [7:0] seq_q;

    // Bumped at the tail-consume edge so the very next head already carries the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q <= 8'd0;
        end else if (tail_done) begin
            seq_q <= seq_q + 8'd1;
        end
    end
    assign seq_val = seq_q;
`else
    assign seq_val = 8'd0;
`endif

    always_comb begin
        state_d    = state_q;
        flit_d     = flit_q;
        rem_d      = rem_q;
        pkt_sent_d = 1'b0;
        err_len_d  = 1'b0;
        if (state_q == IDLE) begin
            if (req_valid && len_ok) begin
                flit_d  = {1'b1, 2'b01, req_dest_x, req_dest_y, 3'(SRC_X), 3'(SRC_Y),
                           req_len, seq_val, 37'd0};
                rem_d   = req_len;
                state_d = HEAD;
            end else if (req_valid) begin
                err_len_d = 1'b1;
            end
        end else if (data_hs) begin
            flit_d  = {1'b1, (rem_q == 4'd1) ? 2'b10 : 2'b00, 29'd0, data};
            rem_d   = rem_q - 4'd1;
            state_d = PAYLOAD;
        end else if (consume) begin
            flit_d = 64'd0;
            if (tail_done) begin
                state_d    = IDLE;
                pkt_sent_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            flit_q     <= 64'd0;
            rem_q      <= 4'd0;
            pkt_sent_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            flit_q     <= flit_d;
            rem_q      <= rem_d;
            pkt_sent_q <= pkt_sent_d;
            err_len_q  <= err_len_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign data_ready = data_rdy;
    assign flit_out   = flit_q;
    assign busy       = (state_q != IDLE);
    assign pkt_sent   = pkt_sent_q;
    assign err_len    = err_len_q;

endmodule

// File: tb/tb_ni_tx.sv
// Testbench for ni_tx: randomized packets checked against a queue-based flit model.
// Honours NI_TX_SEQ_EN so the expected head sequence field tracks the build option.
module tb_ni_tx;
    localparam int SRC_X   = 1;
    localparam int SRC_Y   = 1;
    localparam int MAX_LEN = 8;

    logic        clk, rst_n;
    logic        req_valid, req_ready;
    logic [2:0]  req_dest_x, req_dest_y;
    logic [3:0]  req_len;
    logic        data_valid, data_ready;
    logic [31:0] data;
    logic [63:0] flit_out;
    logic        link_ready, busy, pkt_sent, err_len;

    int tests = 0;
    int fails = 0;
    int sent_count = 0;

    ni_tx #(.SRC_X(SRC_X), .SRC_Y(SRC_Y), .MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_len(req_len),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .flit_out(flit_out), .link_ready(link_ready),
        .busy(busy), .pkt_sent(pkt_sent), .err_len(err_len)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int exp_seq();
`ifdef NI_TX_SEQ_EN
        return sent_count % 256;
`else
        return 0;
`endif
    endfunction

    function automatic logic [63:0] head_f(input int dx, input int dy, input int len, input int seq);
        return (64'h1 << 63) + (64'h1 << 61) + (64'(dx) << 58) + (64'(dy) << 55) +
               (64'(SRC_X) << 52) + (64'(SRC_Y) << 49) + (64'(len) << 45) + (64'(seq) << 37);
    endfunction

    function automatic logic [63:0] pay_f(input logic [31:0] w, input bit tail);
        return (64'h1 << 63) + (tail ? (64'h2 << 61) : 64'h0) + 64'(w);
    endfunction

    // Called just after a negedge with the block idle; returns just after the pkt_sent negedge.
    task automatic send_pkt(input int dx, input int dy, input int len, input int lr_pct,
                            input logic [7:0] dv_mask, input int stall, input logic [31:0] base,
                            input bit fixed, output int cycles, output int bubbles);
        logic [63:0] expq[$];
        logic [63:0] prev, got;
        logic [31:0] w;
        bit prev_held, done, lr, dv, exp_dr;
        int loaded, cyc;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL req_ready_idle: got %b expected 1", req_ready);
        end
        req_valid = 1'b1; req_dest_x = 3'(dx); req_dest_y = 3'(dy); req_len = 4'(len);
        expq.push_back(head_f(dx, dy, len, exp_seq()));
        loaded = 0; cyc = 0; bubbles = 0; prev_held = 0; done = 0; prev = '0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            if (prev_held) begin
                tests++;
                if (flit_out !== prev) begin
                    fails++;
                    $display("FAIL flit_hold: got %h expected %h", flit_out, prev);
                end
            end
            if (pkt_sent === 1'b1) begin
                done = 1;
                tests++;
                if (flit_out !== 64'd0 || busy !== 1'b0 || req_ready !== 1'b1 || expq.size() != 0) begin
                    fails++;
                    $display("FAIL pkt_end: got flit=%h busy=%b req_ready=%b pending=%0d expected flit=0 busy=0 req_ready=1 pending=0",
                             flit_out, busy, req_ready, expq.size());
                end
                sent_count++;
                req_valid = 1'b0; data_valid = 1'b0;
            end else begin
                tests++;
                if (busy !== 1'b1 || flit_out[63] !== (expq.size() != 0)) begin
                    fails++;
                    $display("FAIL busy_valid: got busy=%b valid=%b expected busy=1 valid=%b",
                             busy, flit_out[63], expq.size() != 0);
                end
                if (!flit_out[63]) bubbles++;
                req_valid = (cyc == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
                req_dest_x = 3'($urandom); req_dest_y = 3'($urandom); req_len = 4'($urandom);
                lr = (cyc < stall) ? 1'b0 : ($urandom_range(1, 100) <= lr_pct);
                dv = (loaded < len) && ((dv_mask != 0) ? dv_mask[3'(cyc)] : ($urandom_range(0, 1) == 1));
                w  = fixed ? base + 32'(loaded) : $urandom;
                link_ready = lr; data_valid = dv; data = w;
                #1;
                exp_dr = (loaded < len) && (!flit_out[63] || lr);
                tests++;
                if (data_ready !== exp_dr) begin
                    fails++;
                    $display("FAIL data_ready: got %b expected %b (cyc %0d)", data_ready, exp_dr, cyc);
                end
                if (flit_out[63] && lr) begin
                    got = (expq.size() != 0) ? expq.pop_front() : 64'd0;
                    tests++;
                    if (flit_out !== got) begin
                        fails++;
                        $display("FAIL flit_order: got %h expected %h", flit_out, got);
                    end
                end
                if (dv && exp_dr) begin
                    expq.push_back(pay_f(w, loaded == len - 1));
                    loaded++;
                end
                prev = flit_out;
                prev_held = flit_out[63] && !lr;
                cyc++;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL pkt_timeout: got no pkt_sent expected pkt_sent within 400 cycles");
            req_valid = 1'b0; data_valid = 1'b0;
        end
        cycles = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 0; req_dest_x = 0; req_dest_y = 0; req_len = 0;
        data_valid = 0; data = 0; link_ready = 0;
        repeat (3) @(negedge clk);
        tests++;
        if (flit_out !== 64'd0 || busy !== 1'b0 || pkt_sent !== 1'b0 || err_len !== 1'b0 ||
            req_ready !== 1'b1 || data_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got flit=%h busy=%b sent=%b err=%b rr=%b dr=%b expected 0,0,0,0,1,0",
                     flit_out, busy, pkt_sent, err_len, req_ready, data_ready);
        end
        rst_n = 1'b1;
        sent_count = 0;
    endtask

    task automatic test_basic();
        int cy, bu;
        send_pkt(3, 2, 3, 100, 8'hFF, 0, 32'hA0, 1'b1, cy, bu);
        tests++;
        if (cy != 4 || bu != 0) begin
            fails++;
            $display("FAIL basic_rate: got cycles=%0d bubbles=%0d expected cycles=4 bubbles=0", cy, bu);
        end
    endtask

    task automatic test_stall();
        int cy, bu;
        send_pkt(5, 6, 2, 100, 8'hFF, 4, 32'h0, 1'b0, cy, bu);
        tests++;
        if (cy != 7 || bu != 0) begin
            fails++;
            $display("FAIL stall_head: got cycles=%0d bubbles=%0d expected cycles=7 bubbles=0", cy, bu);
        end
    endtask

    task automatic test_err_len();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 2; i++) begin
            req_valid = 1'b1; req_len = (i == 0) ? 4'd0 : 4'(MAX_LEN + 1);
            data_valid = 1'b1; data = $urandom; link_ready = 1'b1;
            @(negedge clk);
            if (err_len === 1'b1) pulses++;
            tests++;
            if (err_len !== 1'b1 || flit_out !== 64'd0 || busy !== 1'b0 || data_ready !== 1'b0) begin
                fails++;
                $display("FAIL err_len_%0d: got err=%b flit=%h busy=%b dr=%b expected 1,0,0,0",
                         i, err_len, flit_out, busy, data_ready);
            end
        end
        req_valid = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (err_len !== 1'b0 || pulses != 2 || flit_out !== 64'd0) begin
            fails++;
            $display("FAIL err_len_end: got err=%b pulses=%0d flit=%h expected 0,2,0", err_len, pulses, flit_out);
        end
    endtask

    task automatic test_gap();
        int cy, bu;
        send_pkt(0, 7, 2, 100, 8'b1001_1001, 0, 32'h0, 1'b0, cy, bu);
        tests++;
        if (cy != 5 || bu != 2) begin
            fails++;
            $display("FAIL gap_bubbles: got cycles=%0d bubbles=%0d expected cycles=5 bubbles=2", cy, bu);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w1, w2;
        int cy, bu;
        w1 = $urandom; w2 = $urandom;
        req_valid = 1'b1; req_dest_x = 3'd4; req_dest_y = 3'd1; req_len = 4'd2;
        link_ready = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; link_ready = 1'b1; data_valid = 1'b1; data = w1;
        @(negedge clk);
        data = w2;
        @(negedge clk);
        link_ready = 1'b0; data_valid = 1'b0;
        tests++;
        if (flit_out !== pay_f(w2, 1'b1)) begin
            fails++;
            $display("FAIL mid_tail: got %h expected %h", flit_out, pay_f(w2, 1'b1));
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (flit_out !== 64'd0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: got flit=%h busy=%b rr=%b expected 0,0,1", flit_out, busy, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sent_count = 0;
        send_pkt(2, 3, 1, 100, 8'hFF, 0, 32'h0, 1'b0, cy, bu);
        tests++;
        if (cy != 2) begin
            fails++;
            $display("FAIL post_reset_pkt: got cycles=%0d expected 2", cy);
        end
    endtask

    task automatic test_random();
        int cy, bu;
        for (int p = 0; p < 25; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b1;
                req_len = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(MAX_LEN + 1, 15));
                @(negedge clk);
                req_valid = 1'b0;
                tests++;
                if (err_len !== 1'b1 || busy !== 1'b0 || flit_out !== 64'd0) begin
                    fails++;
                    $display("FAIL rand_err: got err=%b busy=%b flit=%h expected 1,0,0", err_len, busy, flit_out);
                end
            end
            send_pkt($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, MAX_LEN),
                     $urandom_range(30, 100), 8'h00, 0, 32'h0, 1'b0, cy, bu);
        end
    endtask

    task automatic test_seq();
        int cy, bu;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sent_count = 0;
        for (int p = 0; p < 257; p++) begin
            send_pkt($urandom_range(0, 7), $urandom_range(0, 7), 1, 100, 8'hFF, 0, 32'h0, 1'b0, cy, bu);
        end
        tests++;
        if (sent_count != 257) begin
            fails++;
            $display("FAIL seq_count: got %0d packets expected 257", sent_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_err_len();
        test_gap();
        test_reset_mid();
        test_random();
        test_seq();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
